// File: rtl/if_prefetch_queue_pkg.sv
// if_pkg: shared slot type, NOP encoding and level-width helper
// for the instruction prefetch queue.
package if_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         instr;
    logic                filled;
  } fetch_slot_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-unit bundle: imem request/response plus ID handshake.
// master = prefetch queue side, slave = memory/ID side.
interface if_prefetch_queue_if
  import if_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();
  logic                      imem_req_valid_o;
  logic                      imem_req_ready_i;
  logic [XLEN-1:0]           imem_req_addr_o;
  logic                      imem_rsp_valid_i;
  logic [31:0]               imem_rsp_data_i;
  logic                      id_valid_o;
  logic                      id_ready_i;
  logic [31:0]               id_instr_o;
  logic [XLEN-1:0]           id_pc_o;
  logic                      redirect_i;
  logic [XLEN-1:0]           redirect_pc_i;
  logic [lvl_w(DEPTH)-1:0]   level_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    output id_valid_o, id_instr_o, id_pc_o, level_o,
    input  imem_req_ready_i, imem_rsp_valid_i,
    input  imem_rsp_data_i, id_ready_i,
    input  redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    input  id_valid_o, id_instr_o, id_pc_o, level_o,
    output imem_req_ready_i, imem_rsp_valid_i,
    output imem_rsp_data_i, id_ready_i,
    output redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_prefetch_queue_slot_ring.sv
// fetch_slot_ring: DEPTH slots walked by alloc/fill/read pointers;
// full/empty come from the counts, never from pointer equality.
module fetch_slot_ring
  import if_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = lvl_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_en_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_en_i,
  input  logic [31:0]     fill_data_i,
  input  logic            rd_en_i,
  output fetch_slot_t     head_o,
  output logic [CW-1:0]   alloc_cnt_o,
  output logic [CW-1:0]   fill_cnt_o
);
  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_o = slots[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      alloc_cnt_o <= '0;
      fill_cnt_o  <= '0;
      for (int i = 0; i < DEPTH; i++)
        slots[i].filled <= 1'b0;
    end else begin
      if (alloc_en_i) begin
        slots[alloc_ptr].pc     <= PC_MAX_W'(alloc_pc_i);
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill_en_i) begin
        slots[fill_ptr].instr  <= fill_data_i;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      // read last: a bypassed slot is freed without staying filled
      if (rd_en_i) begin
        slots[rd_ptr].filled <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      alloc_cnt_o <= alloc_cnt_o + CW'(alloc_en_i)
                   - CW'(rd_en_i);
      fill_cnt_o  <= fill_cnt_o + CW'(fill_en_i)
                   - CW'(rd_en_i);
    end
  end
endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetch PC, inflight/drop tracking.
// Define FETCH_BYPASS_EN for same-cycle response-to-ID bypass.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  if_prefetch_queue_if.master bus
);
  localparam int CW = lvl_w(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   fill_cnt;
  logic [CW-1:0]   pending;
  fetch_slot_t     head;
  logic            req_acc;
  logic            rsp;
  logic            drop_now;
  logic            fill_en;
  logic            bypass;
  logic            deq;
  logic            unused_pc;

  assign bus.imem_req_valid_o = !rst_i
    && (alloc_cnt < CW'(DEPTH))
    && (inflight < CW'(MAX_OUTSTANDING));
  assign bus.imem_req_addr_o = fetch_pc;

  assign req_acc  = bus.imem_req_valid_o
                  & bus.imem_req_ready_i;
  assign rsp      = bus.imem_rsp_valid_i;
  assign drop_now = drop_cnt != '0;
  assign fill_en  = rsp & ~drop_now;
  assign pending  = inflight + CW'(req_acc) - CW'(rsp);

`ifdef FETCH_BYPASS_EN
  assign bypass = fill_en & (fill_cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  assign bus.id_valid_o = head.filled | bypass;
  assign deq = bus.id_valid_o & bus.id_ready_i;
  assign bus.level_o = fill_cnt;
  assign unused_pc = ^head.pc;

  always_comb begin
    bus.id_instr_o = NOP_INSTR;
    bus.id_pc_o    = '0;
    if (bus.id_valid_o) begin
      bus.id_pc_o    = head.pc[XLEN-1:0];
      bus.id_instr_o = head.filled ? head.instr
                                   : bus.imem_rsp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= pending;
      // this cycle's accept/response are pre-redirect
      if (bus.redirect_i) begin
        fetch_pc <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        drop_cnt <= pending;
      end else begin
        if (req_acc)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && drop_now)
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_slot_ring #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.redirect_i),
    .alloc_en_i  (req_acc),
    .alloc_pc_i  (fetch_pc),
    .fill_en_i   (fill_en),
    .fill_data_i (bus.imem_rsp_data_i),
    .rd_en_i     (deq),
    .head_o      (head),
    .alloc_cnt_o (alloc_cnt),
    .fill_cnt_o  (fill_cnt)
  );
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: in-order variable-latency
// memory model, expected-ID queue, directed and random phases.
module tb_if_prefetch_queue;
  import if_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'h100;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();

  if_prefetch_queue #(
    .XLEN            (XLEN),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_deq = 0;
  logic [31:0] exp_q[$];
  int          mem_t[$];
  logic [31:0] mem_a[$];
  int          last_due = 0;
  logic [31:0] exp_fetch = RPC;
  int lat = 1;
  int rdy_pct = 100;
  int idr_pct = 100;
  int redir_pct = 0;
  bit rsp_now = 1'b0;
  bit flush_pend = 1'b0;
  bit coinc = 1'b0;
  bit after_redir = 1'b0;
  bit hold_v = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  // request observer: address model, outstanding bound, memory model
  always @(negedge clk) begin
    int l, due;
    if (!rst) begin
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        chk("req_addr", bus.imem_req_addr_o, exp_fetch);
        chk("outstanding", 64'((mem_t.size() + int'(rsp_now)) < MAXO), 1);
        l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_t.push_back(due);
        mem_a.push_back(exp_fetch);
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (bus.redirect_i) begin
        exp_fetch = {bus.redirect_pc_i[31:2], 2'b00};
        flush_pend = 1'b1;
      end
    end
  end

  // ID monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    logic [31:0] pc;
    if (!rst) begin
      if (after_redir) begin
        chk("level_after_redirect", bus.level_o, 0);
        chk("valid_after_redirect", bus.id_valid_o, 0);
      end
      if (!bus.id_valid_o)
        chk("idle_nop", bus.id_instr_o, NOP_INSTR);
      if (hold_v) begin
        chk("hold_valid", bus.id_valid_o, 1);
        chk("hold_pc", bus.id_pc_o, hold_pc);
        chk("hold_instr", bus.id_instr_o, hold_instr);
      end
      after_redir = bus.redirect_i;
      hold_v = bus.id_valid_o && !bus.id_ready_i && !bus.redirect_i;
      hold_pc = bus.id_pc_o;
      hold_instr = bus.id_instr_o;
      if (bus.id_valid_o && bus.id_ready_i) begin
        n_deq++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL id_unexpected: got pc %0h required none",
                   bus.id_pc_o);
        end else begin
          pc = exp_q.pop_front();
          chk("id_pc", bus.id_pc_o, pc);
          chk("id_instr", bus.id_instr_o, mem_word(pc));
        end
      end
    end
  end

  task automatic step(input int mode, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    if (flush_pend) begin
      exp_q.delete();
      flush_pend = 1'b0;
    end
    if (mem_t.size() > 0 && mem_t[0] <= cyc) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i = mem_word(mem_a[0]);
      void'(mem_t.pop_front());
      void'(mem_a.pop_front());
      rsp_now = 1'b1;
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i = $urandom;
      rsp_now = 1'b0;
    end
    bus.imem_req_ready_i = ($urandom_range(0, 99) < rdy_pct);
    bus.id_ready_i = ($urandom_range(0, 99) < idr_pct);
    bus.redirect_pc_i = (mode == 1) ? rpc : $urandom;
    bus.redirect_i = (mode == 1) ||
                     ($urandom_range(0, 99) < redir_pct);
    if (mode == 2) begin
      #1;
      if (rsp_now && bus.id_valid_o && bus.id_ready_i) begin
        bus.redirect_i = 1'b1;
        coinc = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 32'h0);
  endtask

  initial begin
    int d0, i;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i = '0;
    bus.id_ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", bus.imem_req_valid_o, 0);
    chk("rst_id_valid", bus.id_valid_o, 0);
    chk("rst_id_instr", bus.id_instr_o, NOP_INSTR);
    chk("rst_id_pc", bus.id_pc_o, 0);
    chk("rst_level", bus.level_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run(16);

    idr_pct = 0;
    run(10);
    @(negedge clk);
    chk("stall_level", bus.level_o, DEPTH);
    chk("stall_req_valid", bus.imem_req_valid_o, 0);
    idr_pct = 100;
    run(8);

    lat = 5;
    d0 = n_deq;
    run(36);
    chk("lat5_throughput", 64'((n_deq - d0) >= 8 && (n_deq - d0) <= 16), 1);

    lat = 3;
    run(3);
    step(1, 32'h2002);
    run(20);

    lat = 2;
    coinc = 1'b0;
    for (i = 0; i < 40 && !coinc; i++) step(2, 32'h0);
    chk("coincident_found", coinc, 1);
    run(10);

    lat = 0; rdy_pct = 70; idr_pct = 60; redir_pct = 5;
    run(400);

    redir_pct = 0; rdy_pct = 0; idr_pct = 100; lat = 3;
    step(1, 32'h3000);
    for (i = 0; i < 60 && (mem_t.size() > 0 || rsp_now); i++)
      step(0, 32'h0);
    chk("drain_done", 64'(mem_t.size() == 0 && !rsp_now), 1);
    run(3);
    rdy_pct = 100;
    step(0, 32'h0);
    @(negedge clk);
    chk("byp_req_valid", bus.imem_req_valid_o, 1);
    rdy_pct = 0;
    for (i = 0; i < 20 && !rsp_now; i++) step(0, 32'h0);
    @(negedge clk);
    chk("byp_rsp_seen", rsp_now, 1);
    chk("byp_same_cycle", bus.id_valid_o, BYP);
    chk("byp_same_level", bus.level_o, 0);
    step(0, 32'h0);
    @(negedge clk);
    chk("byp_next_cycle", bus.id_valid_o, !BYP);
    chk("byp_next_level", bus.level_o, BYP ? 0 : 1);
    rdy_pct = 100;
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
